mem_port_arbiter: RTL and testbench

//  Shares the single EX-stage data-memory port (RIB master side) between three requesters:
//  the core EX stage, the send unit (read-only) and the fire unit (read/write).

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the single EX-stage data-memory port (RIB master side) between the
//   core EX stage, the send unit (read-only) and the fire unit (read/write).
//   When the port is idle the core passes straight through with no added
//   latency. The two coprocessors win the port through a registered grant,
//   alternating round-robin between themselves. A coprocessor that has waited
//   long enough pre-empts a requesting core. While the core is locked out,
//   core_hold_o asks ctrl to stall it.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   core_req_i/we/addr/wdata  EX stage request; core_rdata_o returns read data
//   core_hold_o               stall request to ctrl while the core is locked out
//   snd_req_i/addr            send unit read request; snd_gnt_o/snd_rdata_o
//   fire_req_i/we/addr/wdata  fire unit request; fire_gnt_o/fire_rdata_o
//   bus_req_o/we/addr/wdata   shared memory port request side
//   bus_rdata_i, bus_hold_i   shared memory port read data and stall
//   owner_o                   0 idle/core, 1 send, 2 fire
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_HOLD     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_hold_o,
  input  logic              snd_req_i,
  input  logic [ADDR_W-1:0] snd_addr_i,
  output logic              snd_gnt_o,
  output logic [DATA_W-1:0] snd_rdata_o,
  input  logic              fire_req_i,
  input  logic              fire_we_i,
  input  logic [ADDR_W-1:0] fire_addr_i,
  input  logic [DATA_W-1:0] fire_wdata_i,
  output logic              fire_gnt_o,
  output logic [DATA_W-1:0] fire_rdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_hold_i,
  output logic [1:0]        owner_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIRE = 2'd2
  } state_t;

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q;
  state_t            state_d;
  logic              rr_fire_q;
  logic [WAIT_W-1:0] snd_wait_q;
  logic [WAIT_W-1:0] fire_wait_q;
  logic [HOLD_W-1:0] hold_cnt_q;

  logic snd_elig;
  logic fire_elig;
  logic pick_snd;
  logic pick_fire;
  logic owner_req;
  logic release_owner;

  // Arbitration terms. A coprocessor may only take the port from a quiet
  // core, unless it has starved long enough to pre-empt. Picks are blocked
  // while the bus is stalled so the core's in-flight request stays on the bus.
  always_comb begin
    snd_elig      = snd_req_i  && (!core_req_i || (snd_wait_q  == WAIT_MAX));
    fire_elig     = fire_req_i && (!core_req_i || (fire_wait_q == WAIT_MAX));
    pick_snd      = (state_q == IDLE) && !bus_hold_i && snd_elig &&
                    (!fire_elig || !rr_fire_q);
    pick_fire     = (state_q == IDLE) && !bus_hold_i && fire_elig &&
                    (!snd_elig || rr_fire_q);
    owner_req     = (state_q == SEND) ? snd_req_i :
                    (state_q == FIRE) ? fire_req_i : 1'b0;
    release_owner = !bus_hold_i && (!owner_req || (hold_cnt_q == HOLD_LAST));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A tenure ends when the owner lets go or its hold
  // budget runs out; the port then returns to IDLE for at least one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_snd) begin
          state_d = SEND;
        end else if (pick_fire) begin
          state_d = FIRE;
        end
      end
      SEND, FIRE: begin
        if (release_owner) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-robin pointer, tenure length counter and per-coprocessor wait
  // counters. Every grant points the round-robin at the other coprocessor,
  // so a released owner never gets first claim on the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_fire_q   <= 1'b0;
      hold_cnt_q  <= '0;
      snd_wait_q  <= '0;
      fire_wait_q <= '0;
    end else begin
      if (pick_snd) begin
        rr_fire_q <= 1'b1;
      end else if (pick_fire) begin
        rr_fire_q <= 1'b0;
      end

      if ((state_q == IDLE) || (state_d != state_q)) begin
        hold_cnt_q <= '0;
      end else if (!bus_hold_i) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end

      if (!snd_req_i || (state_q == SEND) || pick_snd) begin
        snd_wait_q <= '0;
      end else if (snd_wait_q != WAIT_MAX) begin
        snd_wait_q <= snd_wait_q + 1'b1;
      end

      if (!fire_req_i || (state_q == FIRE) || pick_fire) begin
        fire_wait_q <= '0;
      end else if (fire_wait_q != WAIT_MAX) begin
        fire_wait_q <= fire_wait_q + 1'b1;
      end
    end
  end

  // Output logic: the bus mux follows the current owner. In IDLE a pre-empting
  // pick withdraws the core's request and stalls it for that cycle. Request
  // and stall are forced low while reset is asserted.
  always_comb begin
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_wdata_o  = '0;
    core_hold_o  = 1'b0;
    core_rdata_o = '0;
    snd_gnt_o    = 1'b0;
    snd_rdata_o  = '0;
    fire_gnt_o   = 1'b0;
    fire_rdata_o = '0;
    owner_o      = state_q;
    case (state_q)
      IDLE: begin
        bus_req_o    = core_req_i && !(pick_snd || pick_fire);
        bus_we_o     = core_we_i;
        bus_addr_o   = core_addr_i;
        bus_wdata_o  = core_wdata_i;
        core_hold_o  = core_req_i && (bus_hold_i || pick_snd || pick_fire);
        core_rdata_o = bus_rdata_i;
      end
      SEND: begin
        bus_req_o    = snd_req_i;
        bus_addr_o   = snd_addr_i;
        core_hold_o  = core_req_i;
        snd_gnt_o    = 1'b1;
        snd_rdata_o  = bus_rdata_i;
      end
      FIRE: begin
        bus_req_o    = fire_req_i;
        bus_we_o     = fire_we_i;
        bus_addr_o   = fire_addr_i;
        bus_wdata_o  = fire_wdata_i;
        core_hold_o  = core_req_i;
        fire_gnt_o   = 1'b1;
        fire_rdata_o = bus_rdata_i;
      end
      default: begin
        owner_o = 2'd0;
      end
    endcase
    if (!rst) begin
      bus_req_o   = 1'b0;
      core_hold_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Directed bench for mem_port_arbiter: core pass-through, coprocessor
//   round-robin, starvation pre-emption, tenure limit, bus stall stretching a
//   tenure, and asynchronous reset during a tenure.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              core_req_i;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic [DATA_W-1:0] core_rdata_o;
  logic              core_hold_o;
  logic              snd_req_i;
  logic [ADDR_W-1:0] snd_addr_i;
  logic              snd_gnt_o;
  logic [DATA_W-1:0] snd_rdata_o;
  logic              fire_req_i;
  logic              fire_we_i;
  logic [ADDR_W-1:0] fire_addr_i;
  logic [DATA_W-1:0] fire_wdata_i;
  logic              fire_gnt_o;
  logic [DATA_W-1:0] fire_rdata_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_hold_i;
  logic [1:0]        owner_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(8),
    .MAX_HOLD(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_req_i(core_req_i),
    .core_we_i(core_we_i),
    .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i),
    .core_rdata_o(core_rdata_o),
    .core_hold_o(core_hold_o),
    .snd_req_i(snd_req_i),
    .snd_addr_i(snd_addr_i),
    .snd_gnt_o(snd_gnt_o),
    .snd_rdata_o(snd_rdata_o),
    .fire_req_i(fire_req_i),
    .fire_we_i(fire_we_i),
    .fire_addr_i(fire_addr_i),
    .fire_wdata_i(fire_wdata_i),
    .fire_gnt_o(fire_gnt_o),
    .fire_rdata_o(fire_rdata_o),
    .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_hold_i(bus_hold_i),
    .owner_o(owner_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Moves to just after the next rising edge, where inputs are changed.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  // Records the value an output is required to show this cycle.
  task automatic expect_output(input logic [31:0] value);
    sb_q.push_back(value);
  endtask

  // Takes the oldest recorded requirement and compares the observed output.
  task automatic check_output(input string tag, input logic [31:0] observed);
    logic [31:0] want;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s: observed %h with no expected value queued", tag, observed);
    end else begin
      want = sb_q.pop_front();
      assert (observed === want) else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, want);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    core_req_i   = 1'b1;
    core_we_i    = 1'b0;
    core_addr_i  = '0;
    core_wdata_i = '0;
    snd_req_i    = 1'b0;
    snd_addr_i   = '0;
    fire_req_i   = 1'b0;
    fire_we_i    = 1'b0;
    fire_addr_i  = '0;
    fire_wdata_i = '0;
    bus_rdata_i  = 32'hCAFE_F00D;
    bus_hold_i   = 1'b0;

    // Reset: outputs quiet even with the core requesting.
    #2;
    expect_output(32'd0); expect_output(32'd0); expect_output(32'd0);
    expect_output(32'd0); expect_output(32'd0);
    check_output("rst_owner", 32'(owner_o));
    check_output("rst_bus_req", 32'(bus_req_o));
    check_output("rst_core_hold", 32'(core_hold_o));
    check_output("rst_snd_gnt", 32'(snd_gnt_o));
    check_output("rst_fire_gnt", 32'(fire_gnt_o));
    core_req_i = 1'b0;
    rst = 1'b1;

    // 1: core alone passes straight through in the same cycle.
    apply_stimulus();
    core_req_i  = 1'b1;
    core_addr_i = 32'h1000_0004;
    expect_output(32'h1000_0004); expect_output(32'd1); expect_output(32'd0);
    expect_output(32'd0); expect_output(32'hCAFE_F00D); expect_output(32'd0);
    #2;
    check_output("t1_bus_addr", bus_addr_o);
    check_output("t1_bus_req", 32'(bus_req_o));
    check_output("t1_core_hold", 32'(core_hold_o));
    check_output("t1_owner", 32'(owner_o));
    check_output("t1_core_rdata", core_rdata_o);
    check_output("t1_snd_rdata", snd_rdata_o);
    core_req_i = 1'b0;

    // 2: both coprocessors together; send wins first, fire follows.
    apply_stimulus();
    snd_req_i    = 1'b1;
    snd_addr_i   = 32'h0000_0200;
    fire_req_i   = 1'b1;
    fire_we_i    = 1'b1;
    fire_addr_i  = 32'h0000_0300;
    fire_wdata_i = 32'h0000_0055;
    expect_output(32'd0); expect_output(32'd0); expect_output(32'd0);
    #2;
    check_output("t2_snd_gnt_early", 32'(snd_gnt_o));
    check_output("t2_owner_early", 32'(owner_o));
    check_output("t2_bus_req_early", 32'(bus_req_o));

    apply_stimulus();
    expect_output(32'd1); expect_output(32'd1); expect_output(32'h200);
    expect_output(32'd0); expect_output(32'd0); expect_output(32'hCAFE_F00D);
    #2;
    check_output("t2_snd_gnt", 32'(snd_gnt_o));
    check_output("t2_owner_send", 32'(owner_o));
    check_output("t2_bus_addr_send", bus_addr_o);
    check_output("t2_bus_we_send", 32'(bus_we_o));
    check_output("t2_fire_gnt_wait", 32'(fire_gnt_o));
    check_output("t2_snd_rdata", snd_rdata_o);
    snd_req_i = 1'b0;

    apply_stimulus();
    expect_output(32'd0); expect_output(32'd0); expect_output(32'd0);
    #2;
    check_output("t2_owner_idle", 32'(owner_o));
    check_output("t2_snd_gnt_drop", 32'(snd_gnt_o));
    check_output("t2_fire_gnt_idle", 32'(fire_gnt_o));

    apply_stimulus();
    expect_output(32'd1); expect_output(32'd2); expect_output(32'd1);
    expect_output(32'h300); expect_output(32'h55);
    #2;
    check_output("t2_fire_gnt", 32'(fire_gnt_o));
    check_output("t2_owner_fire", 32'(owner_o));
    check_output("t2_bus_we_fire", 32'(bus_we_o));
    check_output("t2_bus_addr_fire", bus_addr_o);
    check_output("t2_bus_wdata_fire", bus_wdata_o);
    fire_req_i = 1'b0;
    apply_stimulus();

    // 3: fire starves behind a busy core, then pre-empts it.
    apply_stimulus();
    core_req_i = 1'b1;
    fire_req_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) apply_stimulus();
      expect_output(32'd0); expect_output(32'd0); expect_output(32'd1);
      #2;
      check_output("t3_fire_gnt_wait", 32'(fire_gnt_o));
      check_output("t3_core_hold_wait", 32'(core_hold_o));
      check_output("t3_bus_req_wait", 32'(bus_req_o));
    end
    apply_stimulus();
    expect_output(32'd1); expect_output(32'd0); expect_output(32'd0);
    #2;
    check_output("t3_core_hold_preempt", 32'(core_hold_o));
    check_output("t3_bus_req_preempt", 32'(bus_req_o));
    check_output("t3_fire_gnt_preempt", 32'(fire_gnt_o));
    apply_stimulus();
    expect_output(32'd1); expect_output(32'd2); expect_output(32'd1);
    #2;
    check_output("t3_fire_gnt", 32'(fire_gnt_o));
    check_output("t3_owner", 32'(owner_o));
    check_output("t3_core_hold_locked", 32'(core_hold_o));
    core_req_i = 1'b0;
    fire_req_i = 1'b0;
    apply_stimulus();

    // 4: a long fire request is cut at 16 cycles, idles one, then re-grants.
    apply_stimulus();
    fire_req_i = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) apply_stimulus();
      expect_output(((i >= 1 && i <= 16) || i == 18) ? 32'd1 : 32'd0);
      #2;
      check_output($sformatf("t4_fire_gnt_c%0d", i), 32'(fire_gnt_o));
    end
    fire_req_i = 1'b0;
    apply_stimulus();

    // 5: three stalled cycles inside a send tenure stretch it to 19 cycles.
    apply_stimulus();
    snd_addr_i = 32'h0000_0400;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) apply_stimulus();
      snd_req_i  = (i < 20);
      bus_hold_i = (i >= 3 && i <= 5);
      expect_output((i >= 1 && i <= 19) ? 32'd1 : 32'd0);
      expect_output(32'd0);
      expect_output((i >= 1 && i <= 19) ? 32'd1 : 32'd0);
      #2;
      check_output($sformatf("t5_snd_gnt_c%0d", i), 32'(snd_gnt_o));
      check_output($sformatf("t5_bus_we_c%0d", i), 32'(bus_we_o));
      check_output($sformatf("t5_bus_req_c%0d", i), 32'(bus_req_o));
    end
    bus_hold_i = 1'b0;
    apply_stimulus();

    // 6: reset dropped mid fire tenure clears grant and port at once.
    apply_stimulus();
    fire_req_i = 1'b1;
    apply_stimulus();
    expect_output(32'd1);
    #2;
    check_output("t6_fire_gnt_before", 32'(fire_gnt_o));
    rst = 1'b0;
    #1;
    expect_output(32'd0); expect_output(32'd0); expect_output(32'd0);
    check_output("t6_fire_gnt_reset", 32'(fire_gnt_o));
    check_output("t6_bus_req_reset", 32'(bus_req_o));
    check_output("t6_owner_reset", 32'(owner_o));
    fire_req_i = 1'b0;
    #2;
    rst = 1'b1;
    apply_stimulus();
    expect_output(32'd0); expect_output(32'd0);
    #2;
    check_output("t6_owner_after", 32'(owner_o));
    check_output("t6_fire_gnt_after", 32'(fire_gnt_o));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
